// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller:
// forwarding selects, destination tags and FSM states.
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } tag_t;

   localparam tag_t TAG_NONE = '0;

   typedef enum logic {
      RUN,
      LONG_WAIT
   } state_t;

endpackage

// File: rtl/hazard_match.sv
// Combinational compare of one ID source register
// against one in-flight destination tag.
module hazard_match
   import hazard_pkg::*;
(
   input  logic [4:0] rs,
   input  logic       rs_used,
   input  tag_t       tag,
   input  logic       need_ld,
   output logic       hit
);

   assign hit = rs_used && (rs != 5'd0)
             && tag.valid && tag.wr
             && (tag.rd == rs)
             && (!need_ld || tag.ld);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: tag tracking, registered forwarding,
// load-use stall, branch flush and multi-cycle wait.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int LONG_MAX = 64,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [4:0]       id_rd,
   input  logic             id_reg_write,
   input  logic             id_is_load,
   input  logic             ex_branch_taken,
   input  logic             ex_long_op,
   input  logic             ex_long_done,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             ex_hold,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             long_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int LW = $clog2(LONG_MAX + 1);

   state_t        state, state_nxt;
   tag_t          tag_ex, tag_mem;
   logic [LW-1:0] wait_cnt;
   logic          use1, use2;
   logic          a_ex, b_ex, a_mem, b_mem;
   logic          a_lu, b_lu, lu_hit;
   logic          flush, hold, lu, expire;

   assign use1 = id_valid & id_rs1_used;
   assign use2 = id_valid & id_rs2_used;

   hazard_match u_a_ex (
      .rs(id_rs1), .rs_used(use1), .tag(tag_ex),
      .need_ld(1'b0), .hit(a_ex));
   hazard_match u_b_ex (
      .rs(id_rs2), .rs_used(use2), .tag(tag_ex),
      .need_ld(1'b0), .hit(b_ex));
   hazard_match u_a_mem (
      .rs(id_rs1), .rs_used(use1), .tag(tag_mem),
      .need_ld(1'b0), .hit(a_mem));
   hazard_match u_b_mem (
      .rs(id_rs2), .rs_used(use2), .tag(tag_mem),
      .need_ld(1'b0), .hit(b_mem));
   hazard_match u_a_lu (
      .rs(id_rs1), .rs_used(use1), .tag(tag_ex),
      .need_ld(1'b1), .hit(a_lu));
   hazard_match u_b_lu (
      .rs(id_rs2), .rs_used(use2), .tag(tag_ex),
      .need_ld(1'b1), .hit(b_lu));

   assign lu_hit = a_lu | b_lu;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   // The long op is held in EX from the cycle it starts,
   // so hold is asserted on entry as well as while waiting.
   always_comb begin
      state_nxt = state;
      flush     = 1'b0;
      hold      = 1'b0;
      lu        = 1'b0;
      expire    = 1'b0;
      unique case (state)
         RUN: begin
            if (ex_branch_taken) begin
               flush = 1'b1;
            end else if (ex_long_op && !ex_long_done) begin
               hold      = 1'b1;
               state_nxt = LONG_WAIT;
            end else if (lu_hit) begin
               lu = 1'b1;
            end
         end
         LONG_WAIT: begin
            if (ex_long_done) begin
               state_nxt = RUN;
            end else if (wait_cnt == LW'(LONG_MAX - 1)) begin
               expire    = 1'b1;
               state_nxt = RUN;
            end else begin
               hold = 1'b1;
            end
            if (!hold && lu_hit) lu = 1'b1;
         end
         default: ;
      endcase
      pc_stall     = hold | lu;
      if_id_stall  = hold | lu;
      if_id_flush  = flush;
      id_ex_bubble = flush | lu;
      ex_hold      = hold;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt     <= '0;
         long_timeout <= 1'b0;
      end else begin
         if (state == LONG_WAIT && state_nxt == LONG_WAIT)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
         if (expire) long_timeout <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_ex  <= TAG_NONE;
         tag_mem <= TAG_NONE;
      end else if (hold) begin
         tag_mem <= TAG_NONE;
      end else begin
         tag_mem <= tag_ex;
         if (id_ex_bubble || !id_valid)
            tag_ex <= TAG_NONE;
         else
            tag_ex <= '{valid: 1'b1, rd: id_rd,
                        wr: id_reg_write, ld: id_is_load};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fwd_a <= FWD_RF;
         fwd_b <= FWD_RF;
      end else if (!hold) begin
         if (id_ex_bubble) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
         end else begin
            fwd_a <= a_ex ? FWD_MEM : (a_mem ? FWD_WB : FWD_RF);
            fwd_b <= b_ex ? FWD_MEM : (b_mem ? FWD_WB : FWD_RF);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (pc_stall)    stall_cnt <= stall_cnt + 1'b1;
         if (if_id_flush) flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit
// with LONG_MAX=8 so the timeout path is reachable.
module tb_hazard_ctrl_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_rs1_used, id_rs2_used;
   logic        id_reg_write, id_is_load;
   logic        ex_branch_taken, ex_long_op, ex_long_done;
   logic        pc_stall, if_id_stall, if_id_flush;
   logic        id_ex_bubble, ex_hold, long_timeout;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl_unit #(.LONG_MAX(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_reg_write(id_reg_write),
      .id_is_load(id_is_load),
      .ex_branch_taken(ex_branch_taken),
      .ex_long_op(ex_long_op), .ex_long_done(ex_long_done),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall),
      .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
      .ex_hold(ex_hold), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .long_timeout(long_timeout),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   task automatic drive_id(input logic [4:0] r1, input logic u1,
                           input logic [4:0] r2, input logic u2,
                           input logic [4:0] rd, input logic ld);
      id_valid     = 1'b1;
      id_rs1       = r1;
      id_rs1_used  = u1;
      id_rs2       = r2;
      id_rs2_used  = u2;
      id_rd        = rd;
      id_reg_write = 1'b1;
      id_is_load   = ld;
   endtask

   task automatic nop_id();
      id_valid     = 1'b0;
      id_rs1       = 5'd0;
      id_rs2       = 5'd0;
      id_rs1_used  = 1'b0;
      id_rs2_used  = 1'b0;
      id_rd        = 5'd0;
      id_reg_write = 1'b0;
      id_is_load   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         nop_id();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      nop_id();
      ex_branch_taken = 1'b0;
      ex_long_op = 1'b0;
      ex_long_done = 1'b0;
      #12;
      checks++;
      if ({pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold}
          !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000",
                  {pc_stall, if_id_stall, if_id_flush,
                   id_ex_bubble, ex_hold});
      end
      checks++;
      if ({fwd_a, fwd_b, long_timeout} !== 5'b0) begin
         errors++;
         $display("FAIL reset_fwd: got %b expected 00000",
                  {fwd_a, fwd_b, long_timeout});
      end
      checks++;
      if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d/%0d expected 0/0",
                  stall_cnt, flush_cnt);
      end
      @(negedge clk);
      reset = 1'b0;
      idle(2);
   endtask

   task automatic test_load_use();
      @(negedge clk);
      drive_id(5'd0, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1);
      #1;
      checks++;
      if (pc_stall !== 1'b0) begin
         errors++;
         $display("FAIL lu_lw_nostall: got %b expected 0", pc_stall);
      end
      @(negedge clk);
      drive_id(5'd2, 1'b1, 5'd0, 1'b1, 5'd4, 1'b0);
      #1;
      checks++;
      if ({pc_stall, if_id_stall, id_ex_bubble} !== 3'b111) begin
         errors++;
         $display("FAIL lu_stall: got %b expected 111",
                  {pc_stall, if_id_stall, id_ex_bubble});
      end
      @(negedge clk);
      #1;
      checks++;
      if ({pc_stall, id_ex_bubble, fwd_a} !== 4'b0000) begin
         errors++;
         $display("FAIL lu_one_bubble: got %b expected 0000",
                  {pc_stall, id_ex_bubble, fwd_a});
      end
      @(negedge clk);
      nop_id();
      #1;
      checks++;
      if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
         errors++;
         $display("FAIL lu_fwd: got %b/%b expected 01/00",
                  fwd_a, fwd_b);
      end
      checks++;
      if (stall_cnt !== 16'd1) begin
         errors++;
         $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt);
      end
      idle(2);
   endtask

   task automatic test_fwd_ex();
      @(negedge clk);
      drive_id(5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b0);
      @(negedge clk);
      drive_id(5'd1, 1'b1, 5'd1, 1'b1, 5'd3, 1'b0);
      #1;
      checks++;
      if (pc_stall !== 1'b0) begin
         errors++;
         $display("FAIL ex_nostall: got %b expected 0", pc_stall);
      end
      @(negedge clk);
      nop_id();
      #1;
      checks++;
      if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
         errors++;
         $display("FAIL ex_fwd: got %b/%b expected 10/10",
                  fwd_a, fwd_b);
      end
      idle(2);
   endtask

   task automatic test_newest();
      @(negedge clk);
      drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0);
      @(negedge clk);
      drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0);
      @(negedge clk);
      drive_id(5'd5, 1'b1, 5'd5, 1'b1, 5'd10, 1'b0);
      #1;
      checks++;
      if (pc_stall !== 1'b0) begin
         errors++;
         $display("FAIL newest_nostall: got %b expected 0", pc_stall);
      end
      @(negedge clk);
      nop_id();
      #1;
      checks++;
      if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
         errors++;
         $display("FAIL newest_fwd: got %b/%b expected 10/10",
                  fwd_a, fwd_b);
      end
      idle(2);
      @(negedge clk);
      drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b0);
      @(negedge clk);
      nop_id();
      @(negedge clk);
      drive_id(5'd6, 1'b1, 5'd6, 1'b0, 5'd11, 1'b0);
      @(negedge clk);
      nop_id();
      #1;
      checks++;
      if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
         errors++;
         $display("FAIL mem_fwd: got %b/%b expected 01/00",
                  fwd_a, fwd_b);
      end
      idle(2);
   endtask

   task automatic test_x0();
      @(negedge clk);
      drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
      @(negedge clk);
      drive_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b0);
      #1;
      checks++;
      if (pc_stall !== 1'b0 || id_ex_bubble !== 1'b0) begin
         errors++;
         $display("FAIL x0_nostall: got %b%b expected 00",
                  pc_stall, id_ex_bubble);
      end
      @(negedge clk);
      nop_id();
      #1;
      checks++;
      if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
         errors++;
         $display("FAIL x0_fwd: got %b/%b expected 00/00",
                  fwd_a, fwd_b);
      end
      idle(2);
   endtask

   task automatic test_branch();
      @(negedge clk);
      drive_id(5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
      @(negedge clk);
      drive_id(5'd7, 1'b1, 5'd0, 1'b0, 5'd13, 1'b0);
      ex_branch_taken = 1'b1;
      #1;
      checks++;
      if ({if_id_flush, id_ex_bubble, pc_stall, if_id_stall}
          !== 4'b1100) begin
         errors++;
         $display("FAIL br_flush: got %b expected 1100",
                  {if_id_flush, id_ex_bubble, pc_stall, if_id_stall});
      end
      @(negedge clk);
      ex_branch_taken = 1'b0;
      nop_id();
      #1;
      checks++;
      if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin
         errors++;
         $display("FAIL br_cnt: got %0d/%0d expected 1/1",
                  flush_cnt, stall_cnt);
      end
      checks++;
      if (fwd_a !== 2'b00) begin
         errors++;
         $display("FAIL br_fwd: got %b expected 00", fwd_a);
      end
      idle(2);
   endtask

   task automatic test_long();
      @(negedge clk);
      drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0);
      @(negedge clk);
      drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         drive_id(5'd8, 1'b1, 5'd9, 1'b1, 5'd14, 1'b0);
         ex_long_op   = (k == 0);
         ex_long_done = (k == 5);
         #1;
         checks++;
         if ({pc_stall, if_id_stall, ex_hold, id_ex_bubble}
             !== ((k < 5) ? 4'b1110 : 4'b0000)) begin
            errors++;
            $display("FAIL long_hold k=%0d: got %b expected %b", k,
                     {pc_stall, if_id_stall, ex_hold, id_ex_bubble},
                     (k < 5) ? 4'b1110 : 4'b0000);
         end
      end
      @(negedge clk);
      ex_long_done = 1'b0;
      nop_id();
      #1;
      checks++;
      if (fwd_a !== 2'b00 || fwd_b !== 2'b10) begin
         errors++;
         $display("FAIL long_fwd: got %b/%b expected 00/10",
                  fwd_a, fwd_b);
      end
      checks++;
      if (stall_cnt !== 16'd6 || long_timeout !== 1'b0) begin
         errors++;
         $display("FAIL long_cnt: got %0d/%b expected 6/0",
                  stall_cnt, long_timeout);
      end
      idle(2);
   endtask

   task automatic test_timeout();
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         ex_long_op = (k == 0);
         #1;
         checks++;
         if (ex_hold !== (k < 8) || pc_stall !== (k < 8)) begin
            errors++;
            $display("FAIL to_hold k=%0d: got %b%b expected %b", k,
                     ex_hold, pc_stall, (k < 8));
         end
      end
      checks++;
      if (long_timeout !== 1'b0) begin
         errors++;
         $display("FAIL to_early: got %b expected 0", long_timeout);
      end
      @(negedge clk);
      #1;
      checks++;
      if (long_timeout !== 1'b1 || stall_cnt !== 16'd14) begin
         errors++;
         $display("FAIL to_flag: got %b/%0d expected 1/14",
                  long_timeout, stall_cnt);
      end
      checks++;
      if (ex_hold !== 1'b0) begin
         errors++;
         $display("FAIL to_release: got %b expected 0", ex_hold);
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         ex_long_op = (k == 0);
      end
      #1;
      checks++;
      if (ex_hold !== 1'b1) begin
         errors++;
         $display("FAIL rm_inwait: got %b expected 1", ex_hold);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold,
           long_timeout, fwd_a, fwd_b} !== 10'b0) begin
         errors++;
         $display("FAIL rm_outs: got %b expected 0",
                  {pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
                   ex_hold, long_timeout, fwd_a, fwd_b});
      end
      checks++;
      if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
         errors++;
         $display("FAIL rm_cnt: got %0d/%0d expected 0/0",
                  stall_cnt, flush_cnt);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (ex_hold !== 1'b0 || pc_stall !== 1'b0) begin
         errors++;
         $display("FAIL rm_run: got %b%b expected 00",
                  ex_hold, pc_stall);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_fwd_ex();
      test_newest();
      test_x0();
      test_branch();
      test_long();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Central hazard controller for the 5-stage RV32I pipeline core.
- Tracks destination-register tags for the instructions in EX, MEM and WB.
- Generates registered forwarding selects for the EX-stage ALU operands, plus load-use stalls, taken-branch flushes, and a multi-cycle-operation wait with timeout.
- Sits beside the core's pipeline registers and drives their stall, bubble and flush enables.

Parameters:
- LONG_MAX, 64: maximum cycles in LONG_WAIT before forced release with error flag.
- CNT_W, 16: width of the stall and flush event counters (wrap-around).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_used  in  1  instruction reads rs2
- id_rd  in  5  ID destination register
- id_reg_write  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- ex_branch_taken  in  1  taken branch/jump resolved in EX this cycle
- ex_long_op  in  1  EX holds a multi-cycle op that is starting
- ex_long_done  in  1  multi-cycle op result ready
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  zero IF/ID
- id_ex_bubble  out  1  insert NOP into ID/EX
- ex_hold  out  1  hold ID/EX and EX; bubble into EX/MEM
- fwd_a  out  2  rs1 operand select for EX: 00 regfile, 01 MEM/WB, 10 EX/MEM
- fwd_b  out  2  rs2 operand select, same encoding as fwd_a
- long_timeout  out  1  sticky; set on LONG_MAX expiry
- stall_cnt  out  CNT_W  cycles with pc_stall high
- flush_cnt  out  CNT_W  branch flushes taken

Behaviour:

Reset (asynchronous):
- FSM goes to RUN; all tags invalid.
- fwd_a = fwd_b = 00.
- Counters zero; long_timeout 0.
- All stall/flush/bubble outputs 0.

Tag pipeline:
- Three tags: ex, mem, wb. Each tag = {valid, rd, wr, ld}.
- Every cycle without ex_hold: wb<=mem, mem<=ex, ex<=ID info.
- ex loads invalid when id_ex_bubble=1 or id_valid=0.
- Under ex_hold: ex holds, mem<=invalid, wb<=mem.

Hazard match:
- Source rs matches a tag when: rs used, rs≠0, tag valid, tag.wr, tag.rd==rs.
- x0 never matches.

Load-use:
- Trigger: ID source matches ex tag with ld=1.
- Response, combinational same cycle: pc_stall=if_id_stall=id_ex_bubble=1.
- Exactly one bubble per load. After it, the load sits in WB when the consumer reaches EX, and forwarding selects 01.

Forwarding (registered; valid in the cycle the consumer is in EX):
- 10 if the ex tag matches (non-load), else 01 if the mem tag matches, else 00.
- The newer producer wins when both match.
- Selects load 00 whenever a bubble is inserted.
- Selects hold under ex_hold.

Branch flush:
- Trigger: ex_branch_taken=1.
- Response, same cycle: if_id_flush=1 and id_ex_bubble=1.
- Any load-use stall in that cycle is suppressed; pc_stall=0 so the PC accepts the target.
- flush_cnt increments.

FSM states: RUN, LONG_WAIT.
- RUN -> LONG_WAIT when ex_long_op=1 and ex_long_done=0.
- While in LONG_WAIT:
  - pc_stall=if_id_stall=ex_hold=1; id_ex_bubble=0.
  - An internal cycle counter runs.
- LONG_WAIT -> RUN on ex_long_done=1; ex_hold drops that same cycle.
- LONG_WAIT -> RUN when the counter reaches LONG_MAX-1; long_timeout set sticky.
- ex_long_op with ex_long_done in the same cycle: no wait.

Priority: branch flush > LONG_WAIT > load-use > none.
- ex_branch_taken during LONG_WAIT is ignored; the branch is not in EX.

Counters:
- stall_cnt increments each cycle pc_stall=1.
- Both counters wrap at 2^CNT_W.

Reset mid-stall: asynchronous return to RUN. The core owns clearing of the pipeline registers.

The register file must be write-first so that WB→ID needs no forwarding. This block does not check it.

Decomposition:
- Shared package `hazard_pkg`:
  - fwd_sel encoding constants (FWD_RF=00, FWD_WB=01, FWD_MEM=10).
  - Tag struct {valid, rd[4:0], wr, ld}.
  - FSM state enum.
- One natural sub-module: `hazard_match`, a combinational rs-vs-tag comparator.
  - Instantiate 6×: 2 sources × (ex, mem, plus ex-with-load check).

Test Plan:
- addi x1,x0,5; add x3,x1,x1 back-to-back -> fwd_a=fwd_b=10 in add's EX cycle; no stall.
- lw x2,0(x0); add x4,x2,x0 -> one cycle pc_stall=id_ex_bubble=1, then fwd_a=01 in add's EX; stall_cnt=1.
- Producers x5 in EX and x5 in MEM, consumer reads x5 -> fwd=10 (newest wins). Same sequence targeting x0 -> fwd=00, no stall.
- ex_branch_taken=1 while a load-use is detected in ID -> if_id_flush=id_ex_bubble=1, pc_stall=0, flush_cnt=1.
- ex_long_op then ex_long_done after 5 cycles -> pc_stall/ex_hold high exactly 5 cycles; mem tag invalid during hold.
- With LONG_MAX=8 and no done -> release after 8 cycles with long_timeout=1. Assert reset mid-wait -> immediate RUN; all outputs at reset values.
